// File: rtl/utm_pkg.sv
// Shared types and constants for the Turing-machine step controller.
package utm_pkg;

  localparam int STATE_W = 8;
  localparam int SYM_W   = 3;

  localparam logic             DIR_LEFT   = 1'b0;
  localparam logic             DIR_RIGHT  = 1'b1;
  localparam logic [STATE_W-1:0] HALT_STATE = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOOKUP,
    S_WRITE,
    S_MOVE,
    S_PAUSE,
    S_HALT,
    S_ERR
  } ctrl_state_t;

endpackage

// File: rtl/utm_onehot_check.sv
// Classifies a one-hot machine state: all-zero (halt) or more than one bit set (corrupt).
module utm_onehot_check
  import utm_pkg::*;
(
  input  logic [STATE_W-1:0] vec,
  output logic               is_zero,
  output logic               is_multi
);

  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign is_zero  = (vec == HALT_STATE);
  assign is_multi = |(vec & (vec - 8'd1));

endmodule

// File: rtl/utm_step_controller.sv
// Step sequencer for a Turing machine: read tape, look up external table, write, move.
// Optional step limit enabled by defining UTM_STEP_LIMIT_EN.
module utm_step_controller
  import utm_pkg::*;
#(
  parameter int                 STEP_W     = 16,
  parameter logic [STATE_W-1:0] INIT_STATE = 8'h01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               run,
  output logic               tape_rd_req,
  input  logic               tape_rd_ack,
  input  logic [SYM_W-1:0]   tape_sym,
  output logic [STATE_W-1:0] tbl_state,
  output logic [SYM_W-1:0]   tbl_sym,
  input  logic [SYM_W-1:0]   tbl_new_sym,
  input  logic               tbl_dir,
  input  logic [STATE_W-1:0] tbl_next_state,
  output logic               tape_wr_en,
  output logic [SYM_W-1:0]   tape_wr_sym,
  output logic               head_mv,
  output logic               head_dir,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [STEP_W-1:0]  step_count
`ifdef UTM_STEP_LIMIT_EN
  ,
  input  logic [STEP_W-1:0]  step_limit,
  output logic               limit_hit
`endif
);

  ctrl_state_t        state;
  logic [STATE_W-1:0] cur_state;
  logic [STATE_W-1:0] next_reg;
  logic [SYM_W-1:0]   sym_reg;
  logic [SYM_W-1:0]   new_sym_reg;
  logic               dir_reg;
  logic               next_zero;
  logic               next_multi;
  logic [STEP_W-1:0]  count_inc;
  logic               limit_reached;

  utm_onehot_check u_check (
    .vec      (next_reg),
    .is_zero  (next_zero),
    .is_multi (next_multi)
  );

  assign count_inc = (&step_count) ? step_count : step_count + 1'b1;

`ifdef UTM_STEP_LIMIT_EN
  assign limit_reached = (step_limit != '0) && (count_inc == step_limit);
`else
  assign limit_reached = 1'b0;
`endif

  assign tbl_sym     = sym_reg;
  assign tape_wr_sym = new_sym_reg;
  assign head_dir    = dir_reg;
  assign busy   = (state == S_READ) || (state == S_LOOKUP) ||
                  (state == S_WRITE) || (state == S_MOVE);
  assign halted = (state == S_HALT);
  assign error  = (state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur_state   <= INIT_STATE;
      next_reg    <= '0;
      sym_reg     <= '0;
      new_sym_reg <= '0;
      dir_reg     <= DIR_LEFT;
      tbl_state   <= '0;
      step_count  <= '0;
      tape_rd_req <= 1'b0;
      tape_wr_en  <= 1'b0;
      head_mv     <= 1'b0;
`ifdef UTM_STEP_LIMIT_EN
      limit_hit   <= 1'b0;
`endif
    end else begin
      tape_wr_en <= 1'b0;
      head_mv    <= 1'b0;
      case (state)
        S_IDLE, S_PAUSE, S_HALT, S_ERR: begin
          if (start) begin
            state       <= S_READ;
            cur_state   <= INIT_STATE;
            step_count  <= '0;
            tape_rd_req <= 1'b1;
`ifdef UTM_STEP_LIMIT_EN
            limit_hit   <= 1'b0;
`endif
          end else if (state == S_PAUSE && run) begin
            state       <= S_READ;
            tape_rd_req <= 1'b1;
          end
        end
        S_READ: begin
          if (tape_rd_ack) begin
            sym_reg     <= tape_sym;
            tbl_state   <= cur_state;
            tape_rd_req <= 1'b0;
            state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          new_sym_reg <= tbl_new_sym;
          dir_reg     <= tbl_dir;
          next_reg    <= tbl_next_state;
          tape_wr_en  <= 1'b1;
          state       <= S_WRITE;
        end
        S_WRITE: begin
          head_mv <= 1'b1;
          state   <= S_MOVE;
        end
        S_MOVE: begin
          // run is only consulted here, so dropping it mid-step never aborts a step
          cur_state  <= next_reg;
          step_count <= count_inc;
          if (next_zero) begin
            state <= S_HALT;
          end else if (next_multi) begin
            state <= S_ERR;
          end else if (limit_reached) begin
            state <= S_HALT;
`ifdef UTM_STEP_LIMIT_EN
            limit_hit <= 1'b1;
`endif
          end else if (run) begin
            state       <= S_READ;
            tape_rd_req <= 1'b1;
          end else begin
            state <= S_PAUSE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
